// File: rtl/prpg_pkg.sv
// Shared constants and state encoding for the 10-bit PRPG and its BIST sequencer.
// The step function is the x^10+x^3+1 shift used by both the PRPG and the MISR.
package prpg_pkg;

    localparam int PRPG_W   = 10;
    localparam int PRPG_TAP = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_RUN   = 2'd2,
        ST_FLUSH = 2'd3
    } bist_state_e;

    function automatic logic [PRPG_W-1:0] prpg_step(input logic [PRPG_W-1:0] s);
        return {s[PRPG_W-2:0], s[PRPG_W-1] ^ s[PRPG_TAP]};
    endfunction

endpackage

// File: rtl/prpg_bist_ctrl_misr10.sv
// 10-bit MISR built on the PRPG polynomial; compacts one data word per enabled cycle.
// reset is asynchronous active-low; clear has priority over enable.
module misr10
    import prpg_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              enable,
    input  logic [PRPG_W-1:0] data,
    output logic [PRPG_W-1:0] sig
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sig <= '0;
        end else if (clear) begin
            sig <= '0;
        end else if (enable) begin
            sig <= prpg_step(sig) ^ data;
        end
    end

endmodule

// File: rtl/prpg_bist_ctrl.sv
// BIST sequencer: uploads a seed to the PRPG, runs it for a programmed pattern
// count, compacts the output stream into a MISR signature and reports status.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for Go; flags and signature hold last result
// ST_LOAD  | one cycle of PrpgUpld; count of zero finishes immediately
// ST_RUN   | PrpgStart high for exactly Count cycles (down-counter)
// ST_FLUSH | start dropped; last pattern is absorbed into the MISR
module prpg_bist_ctrl
    import prpg_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic              Clk,
    input  logic              ResetB,
    input  logic              Go,
    input  logic              Abort,
    input  logic [PRPG_W-1:0] CfgSeed,
    input  logic [CNT_W-1:0]  CfgCount,
    output logic              PrpgUpld,
    output logic              PrpgStart,
    output logic [PRPG_W-1:0] PrpgSeed,
    input  logic [PRPG_W-1:0] PrpgOut,
    output logic              Busy,
    output logic              Done,
    output logic              Aborted,
    output logic              SeedErr,
    output logic [PRPG_W-1:0] Signature
);

    bist_state_e       state, state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [PRPG_W-1:0] seed;
    logic              pat_valid;
    logic              done_q, aborted_q, seed_err_q;
    logic              go_ok, seed_bad, abort_run, finish;

    always_ff @(posedge Clk or negedge ResetB) begin
        if (!ResetB) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Abort outranks Go in IDLE and every other transition elsewhere.
    always_comb begin
        state_nxt = state;
        go_ok     = 1'b0;
        seed_bad  = 1'b0;
        abort_run = 1'b0;
        finish    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (Go && !Abort) begin
                    if (CfgSeed == '0) begin
                        seed_bad = 1'b1;
                    end else begin
                        go_ok     = 1'b1;
                        state_nxt = ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
                if (Abort) begin
                    abort_run = 1'b1;
                    state_nxt = ST_IDLE;
                end else if (cnt == '0) begin
                    finish    = 1'b1;
                    state_nxt = ST_IDLE;
                end else begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (Abort) begin
                    abort_run = 1'b1;
                    state_nxt = ST_IDLE;
                end else if (cnt == CNT_W'(1)) begin
                    state_nxt = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (Abort) begin
                    abort_run = 1'b1;
                end else begin
                    finish = 1'b1;
                end
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // pat_valid tracks the PRPG's own start register; an abort kills it so the
    // word already being absorbed this cycle is the last one.
    always_ff @(posedge Clk or negedge ResetB) begin
        if (!ResetB) begin
            seed       <= '0;
            cnt        <= '0;
            pat_valid  <= 1'b0;
            done_q     <= 1'b0;
            aborted_q  <= 1'b0;
            seed_err_q <= 1'b0;
        end else begin
            if (go_ok) begin
                seed <= CfgSeed;
                cnt  <= CfgCount;
            end else if (state == ST_RUN) begin
                cnt <= cnt - CNT_W'(1);
            end

            pat_valid <= (state == ST_RUN) && !abort_run;

            if (go_ok || seed_bad) begin
                done_q <= 1'b0;
            end else if (finish) begin
                done_q <= 1'b1;
            end

            if (go_ok || seed_bad) begin
                aborted_q <= 1'b0;
            end else if (abort_run) begin
                aborted_q <= 1'b1;
            end

            if (go_ok) begin
                seed_err_q <= 1'b0;
            end else if (seed_bad) begin
                seed_err_q <= 1'b1;
            end
        end
    end

    misr10 u_misr (
        .clk    (Clk),
        .reset  (ResetB),
        .clear  (go_ok),
        .enable (pat_valid),
        .data   (PrpgOut),
        .sig    (Signature)
    );

    assign PrpgUpld  = (state == ST_LOAD);
    assign PrpgStart = (state == ST_RUN);
    assign Busy      = (state != ST_IDLE);
    assign PrpgSeed  = seed;
    assign Done      = done_q;
    assign Aborted   = aborted_q;
    assign SeedErr   = seed_err_q;

endmodule

// File: tb/tb_prpg_bist_ctrl.sv
// Directed bench for prpg_bist_ctrl with a behavioural PRPG attached.
// Expected signatures are hand-derived from the x^10+x^3+1 sequence.
module tb_prpg_bist_ctrl;

    logic        Clk = 1'b0;
    logic        ResetB = 1'b0;
    logic        Go = 1'b0;
    logic        Abort = 1'b0;
    logic [9:0]  CfgSeed = '0;
    logic [15:0] CfgCount = '0;
    logic        PrpgUpld, PrpgStart, Busy, Done, Aborted, SeedErr;
    logic [9:0]  PrpgSeed, PrpgOut, Signature;

    int n_chk = 0;
    int n_err = 0;

    prpg_bist_ctrl #(.CNT_W(16)) dut (
        .Clk       (Clk),
        .ResetB    (ResetB),
        .Go        (Go),
        .Abort     (Abort),
        .CfgSeed   (CfgSeed),
        .CfgCount  (CfgCount),
        .PrpgUpld  (PrpgUpld),
        .PrpgStart (PrpgStart),
        .PrpgSeed  (PrpgSeed),
        .PrpgOut   (PrpgOut),
        .Busy      (Busy),
        .Done      (Done),
        .Aborted   (Aborted),
        .SeedErr   (SeedErr),
        .Signature (Signature)
    );

    always #5 Clk = ~Clk;

    // Behavioural PRPG: upload loads the seed, a registered start gates shifting.
    logic [9:0] lfsr;
    logic       prpg_st;
    always_ff @(posedge Clk or negedge ResetB) begin
        if (!ResetB) begin
            lfsr    <= '0;
            prpg_st <= 1'b0;
        end else begin
            prpg_st <= PrpgStart;
            if (PrpgUpld) begin
                lfsr <= PrpgSeed;
            end else if (prpg_st) begin
                lfsr <= {lfsr[8:0], lfsr[9] ^ lfsr[2]};
            end
        end
    end
    assign PrpgOut = lfsr;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic go(input logic [9:0] s, input logic [15:0] c);
        CfgSeed  = s;
        CfgCount = c;
        Go       = 1'b1;
        step();
        Go       = 1'b0;
    endtask

    // Starts a run and waits (bounded) for Done; checks latency, signature, strobes.
    task automatic run_chk(input string tag, input logic [9:0] s, input logic [15:0] c,
                           input logic [9:0] exp_sig, input int exp_lat);
        int cyc, ups, sts;
        go(s, c);
        cyc = 1;
        ups = 0;
        sts = 0;
        while (!Done && cyc < 200) begin
            ups += int'(PrpgUpld);
            sts += int'(PrpgStart);
            step();
            cyc++;
        end
        chk({tag, "_lat"}, cyc, exp_lat);
        chk({tag, "_sig"}, Signature, exp_sig);
        chk({tag, "_upld"}, ups, 1);
        chk({tag, "_start"}, sts, int'(c));
        chk({tag, "_busy"}, Busy, 1'b0);
    endtask

    initial begin
        #12;
        chk("rst_busy", Busy, 1'b0);
        chk("rst_done", Done, 1'b0);
        chk("rst_abrt", Aborted, 1'b0);
        chk("rst_serr", SeedErr, 1'b0);
        chk("rst_sig", Signature, 10'h000);
        chk("rst_ctl", {PrpgUpld, PrpgStart}, 2'b00);
        chk("rst_seed", PrpgSeed, 10'h000);
        ResetB = 1'b1;
        step();

        // Seed 1, count 3, with a stray Go during the run.
        go(10'h001, 16'd3);
        chk("a_c1_ctl", {Busy, PrpgUpld, PrpgStart}, 3'b110);
        step();
        chk("a_c2_ctl", {Busy, PrpgUpld, PrpgStart}, 3'b101);
        CfgSeed = 10'h3FF; CfgCount = 16'd5; Go = 1'b1;
        step();
        Go = 1'b0;
        chk("a_c3_pat", PrpgOut, 10'h001);
        chk("a_c3_busy", Busy, 1'b1);
        step();
        chk("a_c4_pat", PrpgOut, 10'h002);
        step();
        chk("a_c5_pat", PrpgOut, 10'h004);
        chk("a_c5_ctl", {Busy, PrpgUpld, PrpgStart, Done}, 4'b1000);
        step();
        chk("a_c6_done", {Busy, Done}, 2'b01);
        chk("a_c6_sig", Signature, 10'h004);
        chk("a_seed_kept", PrpgSeed, 10'h001);

        run_chk("cnt1", 10'h001, 16'd1, 10'h001, 4);
        run_chk("cnt2", 10'h001, 16'd2, 10'h000, 5);
        run_chk("cnt0", 10'h155, 16'd0, 10'h000, 2);
        run_chk("cnt5", 10'h155, 16'd5, 10'h15E, 8);

        // All-zero seed is rejected; next good Go clears the error.
        go(10'h000, 16'd4);
        chk("z_state", {Busy, PrpgUpld}, 2'b00);
        chk("z_flags", {SeedErr, Done, Aborted}, 3'b100);
        step();
        chk("z_idle", {Busy, PrpgUpld}, 2'b00);
        go(10'h001, 16'd1);
        chk("z_clr", {SeedErr, Busy}, 2'b01);
        for (int i = 0; i < 3; i++) step();
        chk("z_done", {Done, Signature}, {1'b1, 10'h001});

        // Abort in cycle 4 of a 10-pattern run.
        go(10'h155, 16'd10);
        step();
        step();
        step();
        Abort = 1'b1;
        step();
        Abort = 1'b0;
        chk("ab_c5", {Busy, PrpgStart, PrpgUpld, Aborted, Done}, 5'b00010);
        chk("ab_c5_sig", Signature, 10'h000);
        step();
        step();
        chk("ab_hold_sig", Signature, 10'h000);
        chk("ab_hold_flg", {Aborted, Done, Busy}, 3'b100);

        // Go and Abort together in IDLE: nothing starts, flags untouched.
        CfgSeed = 10'h001; CfgCount = 16'd2; Go = 1'b1; Abort = 1'b1;
        step();
        Go = 1'b0; Abort = 1'b0;
        chk("ga_idle", {Busy, PrpgUpld}, 2'b00);
        chk("ga_flags", {Aborted, Done, SeedErr}, 3'b100);
        step();
        chk("ga_still", {Busy, PrpgStart}, 2'b00);

        // Asynchronous reset in the middle of RUN, then a clean run.
        go(10'h001, 16'd10);
        step();
        step();
        step();
        chk("rm_pre", {Busy, PrpgStart, Signature}, {2'b11, 10'h001});
        #2 ResetB = 1'b0;
        #1;
        chk("rm_ctl", {Busy, PrpgUpld, PrpgStart}, 3'b000);
        chk("rm_regs", {PrpgSeed, Signature}, 20'h0);
        chk("rm_flags", {Done, Aborted, SeedErr}, 3'b000);
        #1 ResetB = 1'b1;
        step();
        run_chk("post_rst", 10'h155, 16'd5, 10'h15E, 8);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", n_err, n_chk);
        $fatal(1, "watchdog");
    end

endmodule
